// File: rtl/burst_mem_responder_if.sv
// Burst pmem bus between a cacheline requester (master) and burst_mem_responder (slave).
// Carries 64-bit beats, four per 256-bit line request.
interface burst_mem_responder_if;
  logic        pmem_read;
  logic        pmem_write;
  logic [31:0] pmem_address;
  logic [63:0] pmem_wdata;
  logic [63:0] pmem_rdata;
  logic        pmem_resp;

  modport master (
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );

  modport slave (
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp
  );
endinterface

// File: rtl/burst_mem_responder.sv
// Memory end of the 4-beat burst pmem bus: 256-bit line store answering after LATENCY cycles.
// Optional feature macro PMEM_PROTO_CHECK_EN adds a sticky proto_err output flagging requester misbehaviour.
module burst_mem_responder #(
  parameter int LINE_IDX_W = 8,
  parameter int LATENCY    = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  burst_mem_responder_if.slave pmem
`ifdef PMEM_PROTO_CHECK_EN
  , output logic               proto_err
`endif
);

  localparam int LAT_W = $clog2(LATENCY + 1);
  localparam int WORDS = 4 * (2 ** LINE_IDX_W);

  typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} state_t;

  state_t                state, state_nxt;
  logic [LAT_W-1:0]      lat_cnt, lat_cnt_nxt;
  logic [1:0]            beat, beat_nxt, beat_inc;
  logic [LINE_IDX_W-1:0] idx, idx_nxt;
  logic                  op_write, op_write_nxt;
  logic                  resp, resp_nxt;
  logic [63:0]           rdata, rdata_nxt;
  logic                  mem_we;
  logic                  req;
  logic                  unused_addr;

  // Each line is kept as four 64-bit words addressed by {line index, beat}.
  logic [63:0] store [WORDS];

  assign req            = pmem.pmem_read | pmem.pmem_write;
  assign beat_inc       = beat + 2'd1;
  assign pmem.pmem_resp  = resp;
  assign pmem.pmem_rdata = rdata;
  assign unused_addr    = ^{pmem.pmem_address[4:0], pmem.pmem_address[31:5+LINE_IDX_W]};

  always_comb begin
    state_nxt    = state;
    lat_cnt_nxt  = lat_cnt;
    beat_nxt     = beat;
    idx_nxt      = idx;
    op_write_nxt = op_write;
    resp_nxt     = 1'b0;
    rdata_nxt    = 64'h0;
    mem_we       = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          state_nxt    = WAIT;
          lat_cnt_nxt  = LAT_W'(LATENCY - 1);
          idx_nxt      = pmem.pmem_address[5 +: LINE_IDX_W];
          op_write_nxt = pmem.pmem_write;
        end
      end
      WAIT: begin
        if (lat_cnt == '0) begin
          state_nxt = BURST;
          beat_nxt  = 2'd0;
          resp_nxt  = 1'b1;
          rdata_nxt = op_write ? 64'h0 : store[{idx, 2'd0}];
        end else begin
          lat_cnt_nxt = lat_cnt - LAT_W'(1);
        end
      end
      BURST: begin
        // resp is high throughout BURST, so this edge is a write beat's commit point.
        mem_we = op_write;
        if (beat == 2'd3) begin
          state_nxt = DONE;
          beat_nxt  = 2'd0;
        end else begin
          beat_nxt  = beat_inc;
          resp_nxt  = 1'b1;
          rdata_nxt = op_write ? 64'h0 : store[{idx, beat_inc}];
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      lat_cnt  <= '0;
      beat     <= 2'd0;
      idx      <= '0;
      op_write <= 1'b0;
      resp     <= 1'b0;
      rdata    <= 64'h0;
    end else begin
      state    <= state_nxt;
      lat_cnt  <= lat_cnt_nxt;
      beat     <= beat_nxt;
      idx      <= idx_nxt;
      op_write <= op_write_nxt;
      resp     <= resp_nxt;
      rdata    <= rdata_nxt;
    end
  end

  // Store is not cleared by rst; a beat coinciding with rst is dropped, earlier beats remain.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      store[{idx, beat}] <= pmem.pmem_wdata;
    end
  end

`ifdef PMEM_PROTO_CHECK_EN
  logic [26:0] addr_q;
  logic        busy;
  logic        both;
  logic        proto_hit;

  assign busy      = (state == WAIT) || (state == BURST);
  assign both      = pmem.pmem_read & pmem.pmem_write;
  assign proto_hit = (busy && both)
                   || (state == IDLE && both)
                   || (busy && !req && !(state == BURST && beat == 2'd3))
                   || (busy && (pmem.pmem_address[31:5] != addr_q));

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q    <= '0;
      proto_err <= 1'b0;
    end else begin
      if (state == IDLE && req) begin
        addr_q <= pmem.pmem_address[31:5];
      end
      proto_err <= proto_err | proto_hit;
    end
  end
`endif

endmodule
